// File: rtl/transform_sequencer.sv
// Walks one transform-table line per request: descriptor lookup, then one
// character-memory fetch per word, emitted as lhs/rhs pairs. Optional macro: SEQ_SKIP_BLANK_EN.
module transform_sequencer #(
    parameter int LOOKUP_LAT = 1,
    parameter int MEM_LAT    = 1,
    parameter int MAX_LEN    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_line,
    output logic [7:0]  map_line,
    input  logic [15:0] map_addr,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_lhs,
    output logic [7:0]  out_rhs,
    output logic [7:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [7:0] LP_MAX_LEN    = 8'(MAX_LEN);
    localparam logic [1:0] LP_LOOKUP_END = 2'(LOOKUP_LAT);
    localparam logic [1:0] LP_FETCH_END  = 2'(MEM_LAT);
    localparam logic [7:0] LP_PARK       = 8'hFF;

    state_t     r_state;
    logic [1:0] r_cnt;
    logic [7:0] r_len;
    logic [7:0] r_start;
    logic [7:0] r_index;
    logic [7:0] r_map_line;
    logic [7:0] r_mem_addr;
    logic [7:0] r_lhs;
    logic [7:0] r_rhs;
    logic [7:0] r_out_index;
    logic       r_last;
    logic       r_done;

    logic [7:0] w_len;
    logic [7:0] w_next_index;
    logic [7:0] w_next_addr;
    logic       w_last_word;
    logic       w_skip;

    assign w_len        = (map_addr[15:8] > LP_MAX_LEN) ? LP_MAX_LEN : map_addr[15:8];
    assign w_next_index = r_index + 8'd1;
    // 8-bit add: the walk wraps from 0xFF back to 0x00 by design.
    assign w_next_addr  = r_start + w_next_index;
    assign w_last_word  = (w_next_index == r_len);

`ifdef SEQ_SKIP_BLANK_EN
    assign w_skip = (mem_dout == 16'h2020);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_len       <= 8'd0;
            r_start     <= 8'd0;
            r_index     <= 8'd0;
            r_map_line  <= 8'd0;
            r_mem_addr  <= LP_PARK;
            r_lhs       <= 8'd0;
            r_rhs       <= 8'd0;
            r_out_index <= 8'd0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_map_line <= req_line;
                        r_cnt      <= 2'd0;
                        r_state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (r_cnt == LP_LOOKUP_END) begin
                        r_len   <= w_len;
                        r_start <= map_addr[7:0];
                        r_index <= 8'd0;
                        if (w_len == 8'd0) begin
                            r_done     <= 1'b1;
                            r_mem_addr <= LP_PARK;
                            r_state    <= S_DONE;
                        end else begin
                            r_mem_addr <= map_addr[7:0];
                            r_cnt      <= 2'd0;
                            r_state    <= S_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_FETCH: begin
                    if (r_cnt == LP_FETCH_END) begin
                        if (w_skip) begin
                            // Blank word: advance without an EMIT cycle.
                            r_index <= w_next_index;
                            r_cnt   <= 2'd0;
                            if (w_last_word) begin
                                r_done     <= 1'b1;
                                r_mem_addr <= LP_PARK;
                                r_state    <= S_DONE;
                            end else begin
                                r_mem_addr <= w_next_addr;
                                r_state    <= S_FETCH;
                            end
                        end else begin
                            r_lhs       <= mem_dout[15:8];
                            r_rhs       <= mem_dout[7:0];
                            r_out_index <= r_index;
                            r_last      <= (r_index == (r_len - 8'd1));
                            r_state     <= S_EMIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_index <= w_next_index;
                        r_cnt   <= 2'd0;
                        if (w_last_word) begin
                            r_done     <= 1'b1;
                            r_mem_addr <= LP_PARK;
                            r_state    <= S_DONE;
                        end else begin
                            r_mem_addr <= w_next_addr;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_EMIT);
    assign map_line  = r_map_line;
    assign mem_addr  = r_mem_addr;
    assign out_lhs   = r_lhs;
    assign out_rhs   = r_rhs;
    assign out_index = r_out_index;
    assign out_last  = r_last;
    assign done      = r_done;

endmodule

// File: tb/tb_transform_sequencer.sv
// Directed bench for transform_sequencer with registered mapper/memory models.
module tb_transform_sequencer;

    localparam int LL = 1;
    localparam int ML = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_line;
    logic [7:0]  map_line;
    logic [15:0] map_addr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_lhs;
    logic [7:0]  out_rhs;
    logic [7:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    transform_sequencer #(.LOOKUP_LAT(LL), .MEM_LAT(ML), .MAX_LEN(255)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_line(req_line),
        .map_line(map_line), .map_addr(map_addr),
        .mem_addr(mem_addr), .mem_dout(mem_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lhs(out_lhs), .out_rhs(out_rhs), .out_index(out_index), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] map_tbl [256];
    logic [15:0] mem     [256];
    logic [15:0] map_pipe [LL];
    logic [15:0] mem_pipe [ML];

    always @(posedge clk) begin
        map_pipe[0] <= map_tbl[map_line];
        mem_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < LL; i++) map_pipe[i] <= map_pipe[i-1];
        for (int j = 1; j < ML; j++) mem_pipe[j] <= mem_pipe[j-1];
    end
    assign map_addr = map_pipe[LL-1];
    assign mem_dout = mem_pipe[ML-1];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc, first_v_cyc, done_cyc;
    int done_cnt, valid_cycles, stab_err;
    logic [31:0] pairs[$];
    logic [7:0]  addrs[$];
    logic [7:0]  last_addr;
    logic        prev_v, prev_hs;
    logic [24:0] prev_dat;
    int          ready_mode = 0;   // 0: always 1, 1: pattern 1-0-0-1, 2: always 0
    int          rk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: records handshakes, address changes, done pulses, stability.
    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            acc_cyc = cyc;
            first_v_cyc = -1;
        end
        if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready)
            pairs.push_back({out_lhs, out_rhs, out_index, 7'd0, out_last});
        if (mem_addr !== last_addr) begin
            addrs.push_back(mem_addr);
            last_addr = mem_addr;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid && prev_v && !prev_hs &&
            ({out_lhs, out_rhs, out_index, out_last} !== prev_dat))
            stab_err++;
        prev_v   = out_valid;
        prev_hs  = out_valid && out_ready;
        prev_dat = {out_lhs, out_rhs, out_index, out_last};
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = (rk % 4 == 0) || (rk % 4 == 3);
                2: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            rk++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        pairs.delete();
        addrs.delete();
        done_cnt = 0;
        valid_cycles = 0;
        stab_err = 0;
    endtask

    task automatic request(input logic [7:0] line);
        @(posedge clk);
        #1;
        req_line  = line;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: done timeout observed 0 expected 1", tag);
        end
        @(negedge clk);
    endtask

    task automatic chk_pairs(input string tag, input logic [31:0] exp[$]);
        chk({tag, "_npairs"}, 32'(pairs.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s_pair%0d", tag, i), (i < pairs.size()) ? pairs[i] : 32'hxxxxxxxx, exp[i]);
    endtask

    task automatic chk_addrs(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_naddr"}, 32'(addrs.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 32'((i < addrs.size()) ? addrs[i] : 8'hxx), 32'(exp[i]));
    endtask

    function automatic logic [31:0] pr(input logic [7:0] l, r, ix, input logic last);
        return {l, r, ix, 7'd0, last};
    endfunction

    initial begin
        logic [31:0] ep[$];
        logic [7:0]  ea[$];
        int          dc;

        for (int i = 0; i < 256; i++) begin
            map_tbl[i] = 16'h0000;
            mem[i]     = 16'h0000;
        end
        map_tbl[0] = 16'h0300;
        map_tbl[1] = 16'h0503;
        map_tbl[2] = 16'h0000;
        map_tbl[3] = 16'h03FE;
        map_tbl[4] = 16'h0308;
        mem[8'h00] = 16'h3131; mem[8'h01] = 16'h6162; mem[8'h02] = 16'h7320;
        mem[8'h03] = 16'h3174; mem[8'h04] = 16'h4142; mem[8'h05] = 16'h7320;
        mem[8'h06] = 16'h5E20; mem[8'h07] = 16'h3220;
        mem[8'h08] = 16'h4142; mem[8'h09] = 16'h2020; mem[8'h0A] = 16'h4344;
        mem[8'hFE] = 16'h4445; mem[8'hFF] = 16'h4647;

        rst = 1'b1; req_valid = 1'b0; req_line = 8'd0;
        last_addr = 8'hFF; prev_v = 0; prev_hs = 0; prev_dat = '0;
        first_v_cyc = -1; acc_cyc = 0; done_cyc = 0;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_map_line", 32'(map_line), 32'h00);
        chk("rst_mem_addr", 32'(mem_addr), 32'hFF);
        chk("rst_ctrl", {28'd0, out_valid, req_ready, busy, done}, 32'b0100);
        chk("rst_data", {out_lhs, out_rhs, out_index, 7'd0, out_last}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Line 0: three pairs, ready always high.
        clear_log();
        request(8'd0);
        wait_done("s1");
        ep = '{pr(8'h31, 8'h31, 8'd0, 1'b0), pr(8'h61, 8'h62, 8'd1, 1'b0), pr(8'h73, 8'h20, 8'd2, 1'b1)};
        chk_pairs("s1", ep);
        ea = '{8'h00, 8'h01, 8'h02, 8'hFF};
        chk_addrs("s1", ea);
        chk("s1_done_cnt", 32'(done_cnt), 32'd1);
        chk("s1_first_lat", 32'(first_v_cyc - acc_cyc), 32'd5);

        // Line 1: five pairs under a 1-0-0-1 ready pattern.
        clear_log();
        ready_mode = 1;
        request(8'd1);
        wait_done("s2");
        ready_mode = 0;
        ep = '{pr(8'h31, 8'h74, 8'd0, 1'b0), pr(8'h41, 8'h42, 8'd1, 1'b0), pr(8'h73, 8'h20, 8'd2, 1'b0),
               pr(8'h5E, 8'h20, 8'd3, 1'b0), pr(8'h32, 8'h20, 8'd4, 1'b1)};
        chk_pairs("s2", ep);
        ea = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hFF};
        chk_addrs("s2", ea);
        chk("s2_stable", 32'(stab_err), 32'd0);
        chk("s2_done_cnt", 32'(done_cnt), 32'd1);

        // Zero-length descriptor.
        clear_log();
        request(8'd2);
        wait_done("s3");
        chk("s3_valid_cycles", 32'(valid_cycles), 32'd0);
        chk("s3_done_lat", 32'(done_cyc - acc_cyc), 32'(LL + 2));
        chk("s3_busy_after", {31'd0, busy}, 32'd0);
        chk("s3_done_cnt", 32'(done_cnt), 32'd1);

        // Start address near the top: wraps 0xFF -> 0x00.
        clear_log();
        request(8'd3);
        wait_done("s4");
        ea = '{8'hFE, 8'hFF, 8'h00, 8'hFF};
        chk_addrs("s4", ea);
        ep = '{pr(8'h44, 8'h45, 8'd0, 1'b0), pr(8'h46, 8'h47, 8'd1, 1'b0), pr(8'h31, 8'h31, 8'd2, 1'b1)};
        chk_pairs("s4", ep);

        // Reset while the second pair of line 1 is waiting in EMIT.
        clear_log();
        ready_mode = 2;
        request(8'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        ready_mode = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid && out_index == 8'd1) break;
            if (out_valid) begin
                @(posedge clk);
                #1 out_ready = 1'b0;
                ready_mode = 2;
            end
        end
        chk("s5_in_emit_idx1", {23'd0, out_valid, out_index}, {23'd0, 1'b1, 8'd1});
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 0;
        out_ready = 1'b1;
        dc = done_cnt;
        @(negedge clk);
        chk("s5_after_rst", {22'd0, out_valid, req_ready, mem_addr}, {22'd0, 1'b0, 1'b1, 8'hFF});
        repeat (4) @(negedge clk);
        chk("s5_no_done", 32'(done_cnt), 32'(dc));
        clear_log();
        request(8'd0);
        wait_done("s5b");
        ep = '{pr(8'h31, 8'h31, 8'd0, 1'b0), pr(8'h61, 8'h62, 8'd1, 1'b0), pr(8'h73, 8'h20, 8'd2, 1'b1)};
        chk_pairs("s5b", ep);

        // Blank word in the middle of the line.
        clear_log();
        request(8'd4);
        wait_done("s6");
`ifdef SEQ_SKIP_BLANK_EN
        ep = '{pr(8'h41, 8'h42, 8'd0, 1'b0), pr(8'h43, 8'h44, 8'd2, 1'b1)};
`else
        ep = '{pr(8'h41, 8'h42, 8'd0, 1'b0), pr(8'h20, 8'h20, 8'd1, 1'b0), pr(8'h43, 8'h44, 8'd2, 1'b1)};
`endif
        chk_pairs("s6", ep);
        chk("s6_done_cnt", 32'(done_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
